assignment_info_table: RTL and testbench

ASSIGNMENT_INFO_TABLE -- requirements
Module: assignment_info_table

---
 rtl/assignment_info_table_pkg.sv | 31 +++
 rtl/assignment_info_table_trail_stack.sv | 50 +++++
 rtl/assignment_info_table.sv | 189 ++++++++++++++++++
 tb/tb_assignment_info_table.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/assignment_info_table_pkg.sv
// Shared CDCL definitions: request opcodes, table FSM states and the width
// helpers used to size VIDs, clause IDs and the trail pointer.
package assignment_info_table_pkg;

  typedef enum logic [1:0] {
    OP_ASSIGN = 2'b00,
    OP_LOOKUP = 2'b01,
    OP_SEEN   = 2'b10,
    OP_POP    = 2'b11
  } ait_op_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_RESPOND   = 2'b01,
    ST_BACKTRACK = 2'b10
  } ait_state_e;

  function automatic int vid_width(input int literals);
    return (literals > 1) ? $clog2(literals) : 1;
  endfunction

  function automatic int reason_width(input int clauses);
    return (clauses > 1) ? $clog2(clauses) : 1;
  endfunction

  // The trail pointer must reach "depth" itself, hence depth+1 states.
  function automatic int ptr_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/assignment_info_table_trail_stack.sv
// LIFO of assigned VIDs in assignment order; exposes the top and the entry
// below it so a backtrack can decide its last pop without an extra cycle.
module ait_trail_stack #(
  parameter int DEPTH = 16,
  parameter int W     = 4,
  parameter int PW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_vid,
  output logic [W-1:0]  top_vid,
  output logic [W-1:0]  second_vid,
  output logic [PW-1:0] tp,
  output logic          empty,
  output logic          full
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] tp_reg;
  logic [PW-1:0] tp_m1;
  logic [PW-1:0] tp_m2;

  assign tp_m1      = tp_reg - PW'(1);
  assign tp_m2      = tp_reg - PW'(2);
  assign empty      = (tp_reg == '0);
  assign full       = (tp_reg == PW'(DEPTH));
  assign tp         = tp_reg;
  assign top_vid    = mem[tp_m1[W-1:0]];
  assign second_vid = mem[tp_m2[W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tp_reg <= '0;
    end else if (push && !full) begin
      tp_reg <= tp_reg + PW'(1);
    end else if (pop && !empty) begin
      tp_reg <= tp_m1;
    end
  end

  // Storage is not reset: entries above tp are never observed.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[tp_reg[W-1:0]] <= push_vid;
    end
  end

endmodule

// File: rtl/assignment_info_table.sv
// Per-variable assignment table for a CDCL solver: assign/lookup/mark-seen/
// trail-pop requests plus a multi-cycle backtrack to a target decision level.
module assignment_info_table
  import assignment_info_table_pkg::*;
#(
  parameter int literals = 16,
  parameter int clauses  = 16,
  localparam int VW = vid_width(literals),
  localparam int CW = reason_width(clauses)
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          AIT_enable,
  input  logic [1:0]    AIT_opCode,
  input  logic [VW:0]   AIT_LID,
  input  logic [VW-1:0] Wr_Declevel,
  input  logic [CW-1:0] Wr_Reason,
  input  logic          Bt_en,
  input  logic [VW-1:0] Bt_level,
  input  logic          Clear_seen,
  output logic [VW:0]   AIT_LID_out,
  output logic          AIT_Seen,
  output logic [VW-1:0] AIT_Declevel,
  output logic [CW-1:0] AIT_Reason,
  output logic          AIT_valid,
  output logic          Busy,
  output logic          Trail_empty,
  output logic          Trail_full,
  output logic          Err
);

  localparam int PW = ptr_width(literals);

  ait_state_e state_reg, state_next;
  ait_op_e    op;

  logic [VW-1:0]       bt_level_reg;
  logic [literals-1:0] assigned_reg, assigned_next;
  logic [literals-1:0] seen_reg, seen_next;
  logic                polarity_mem [literals];
  logic [VW-1:0]       declevel_mem [literals];
  logic [CW-1:0]       reason_mem   [literals];

  logic          valid_reg, err_reg, seen_out_reg;
  logic [VW:0]   lid_out_reg;
  logic [VW-1:0] declevel_out_reg;
  logic [CW-1:0] reason_out_reg;

  logic [VW-1:0] vid, resp_vid, top_vid, second_vid, top_lvl, second_lvl;
  logic [PW-1:0] tp;
  logic          empty, full;
  logic          accept, do_assign, do_lookup, do_mark, do_pop;
  logic          bt_pop, bt_last, err_set, valid_next, stk_pop;

  assign op         = ait_op_e'(AIT_opCode);
  assign vid        = AIT_LID[VW-1:0];
  assign top_lvl    = declevel_mem[top_vid];
  assign second_lvl = declevel_mem[second_vid];

  // A simultaneous backtrack request takes the cycle; the request is dropped.
  assign accept    = (state_reg == ST_IDLE) && AIT_enable && !Bt_en;
  assign do_assign = accept && (op == OP_ASSIGN) && !assigned_reg[vid] && !full;
  assign do_lookup = accept && (op == OP_LOOKUP) && assigned_reg[vid];
  assign do_mark   = accept && (op == OP_SEEN);
  assign do_pop    = accept && (op == OP_POP) && !empty;
  assign err_set   = accept && (((op == OP_ASSIGN) && (assigned_reg[vid] || full)) ||
                                ((op == OP_LOOKUP) && !assigned_reg[vid]) ||
                                ((op == OP_POP)    && empty));

  // Backtrack leaves on the same cycle as its final pop by peeking one below.
  assign bt_pop  = (state_reg == ST_BACKTRACK) && !empty && (top_lvl > bt_level_reg);
  assign bt_last = !bt_pop || (tp == PW'(1)) || (second_lvl <= bt_level_reg);

  assign stk_pop    = do_pop || bt_pop;
  assign valid_next = do_lookup || do_pop;
  assign resp_vid   = (op == OP_POP) ? top_vid : vid;

  ait_trail_stack #(
    .DEPTH (literals),
    .W     (VW),
    .PW    (PW)
  ) u_trail (
    .clk        (Clk),
    .rst        (Reset),
    .push       (do_assign),
    .pop        (stk_pop),
    .push_vid   (vid),
    .top_vid    (top_vid),
    .second_vid (second_vid),
    .tp         (tp),
    .empty      (empty),
    .full       (full)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (Bt_en) begin
          state_next = ST_BACKTRACK;
        end else if (AIT_enable && ((op == OP_LOOKUP) || (op == OP_POP))) begin
          state_next = ST_RESPOND;
        end
      end
      ST_RESPOND:   state_next = ST_IDLE;
      ST_BACKTRACK: if (bt_last) state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // Set-seen is applied after the global clear so it wins for its VID.
  always_comb begin
    assigned_next = assigned_reg;
    seen_next     = seen_reg;
    if (do_assign) begin
      assigned_next[vid] = 1'b1;
      seen_next[vid]     = 1'b0;
    end
    if (do_pop) begin
      assigned_next[top_vid] = 1'b0;
    end
    if (Clear_seen) begin
      seen_next = '0;
    end
    if (bt_pop) begin
      assigned_next[top_vid] = 1'b0;
      seen_next[top_vid]     = 1'b0;
    end
    if (do_mark) begin
      seen_next[vid] = 1'b1;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= ST_IDLE;
      bt_level_reg <= '0;
      assigned_reg <= '0;
      seen_reg     <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      assigned_reg <= assigned_next;
      seen_reg     <= seen_next;
      err_reg      <= err_reg | err_set;
      if ((state_reg == ST_IDLE) && Bt_en) begin
        bt_level_reg <= Bt_level;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (do_assign) begin
      polarity_mem[vid] <= AIT_LID[VW];
      declevel_mem[vid] <= Wr_Declevel;
      reason_mem[vid]   <= Wr_Reason;
    end
  end

  // Response fields only move on a valid response and hold otherwise.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_reg        <= 1'b0;
      lid_out_reg      <= '0;
      seen_out_reg     <= 1'b0;
      declevel_out_reg <= '0;
      reason_out_reg   <= '0;
    end else begin
      valid_reg <= valid_next;
      if (valid_next) begin
        lid_out_reg      <= {polarity_mem[resp_vid], resp_vid};
        seen_out_reg     <= seen_reg[resp_vid];
        declevel_out_reg <= declevel_mem[resp_vid];
        reason_out_reg   <= reason_mem[resp_vid];
      end
    end
  end

  assign AIT_valid    = valid_reg;
  assign AIT_LID_out  = lid_out_reg;
  assign AIT_Seen     = seen_out_reg;
  assign AIT_Declevel = declevel_out_reg;
  assign AIT_Reason   = reason_out_reg;
  assign Busy         = (state_reg != ST_IDLE);
  assign Trail_empty  = empty;
  assign Trail_full   = full;
  assign Err          = err_reg;

endmodule

// File: tb/tb_assignment_info_table.sv
// Self-checking bench for assignment_info_table: directed scenarios plus a
// randomized run against a table/queue reference model.
module tb_assignment_info_table;

  localparam int N = 16;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       AIT_enable = 1'b0;
  logic [1:0] AIT_opCode = '0;
  logic [4:0] AIT_LID = '0;
  logic [3:0] Wr_Declevel = '0;
  logic [3:0] Wr_Reason = '0;
  logic       Bt_en = 1'b0;
  logic [3:0] Bt_level = '0;
  logic       Clear_seen = 1'b0;
  logic [4:0] AIT_LID_out;
  logic       AIT_Seen;
  logic [3:0] AIT_Declevel;
  logic [3:0] AIT_Reason;
  logic       AIT_valid, Busy, Trail_empty, Trail_full, Err;

  always #5 Clk = ~Clk;

  assignment_info_table #(.literals(N), .clauses(N)) dut (
    .Clk(Clk), .Reset(Reset), .AIT_enable(AIT_enable), .AIT_opCode(AIT_opCode),
    .AIT_LID(AIT_LID), .Wr_Declevel(Wr_Declevel), .Wr_Reason(Wr_Reason),
    .Bt_en(Bt_en), .Bt_level(Bt_level), .Clear_seen(Clear_seen),
    .AIT_LID_out(AIT_LID_out), .AIT_Seen(AIT_Seen), .AIT_Declevel(AIT_Declevel),
    .AIT_Reason(AIT_Reason), .AIT_valid(AIT_valid), .Busy(Busy),
    .Trail_empty(Trail_empty), .Trail_full(Trail_full), .Err(Err)
  );

  int n_checks = 0;
  int n_pass = 0;

  // Reference model: variable table plus the trail as a queue.
  bit m_assigned[N];
  bit m_pol[N];
  int m_lvl[N];
  int m_rsn[N];
  bit m_seen[N];
  bit m_err;
  int m_trail[$];

  logic       exp_valid;
  logic [4:0] exp_lid;
  logic [3:0] exp_lvl, exp_rsn;
  logic       exp_seen;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_assigned[i] = 0; m_seen[i] = 0;
    end
    m_err = 0;
    m_trail.delete();
  endtask

  task automatic set_exp(input int v);
    exp_valid = 1'b1;
    exp_lid   = 5'(m_pol[v] * N + v);
    exp_lvl   = 4'(m_lvl[v]);
    exp_rsn   = 4'(m_rsn[v]);
    exp_seen  = m_seen[v];
  endtask

  task automatic apply_reset();
    Reset = 1'b1; AIT_enable = 0; Bt_en = 0; Clear_seen = 0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge Clk);
    while (Busy === 1'b1 && n < 64) begin
      @(negedge Clk);
      n++;
    end
    if (Busy !== 1'b0) begin
      n_checks++;
      $display("FAIL idle_timeout: Busy=%b required 0", Busy);
    end
  endtask

  // Drive one request for one cycle; leaves time at posedge+1 for checking.
  task automatic step(input int op, input int lid, input int lvl, input int rsn, input bit clr);
    int v;
    int t;
    wait_idle();
    v = lid % N;
    exp_valid = 1'b0;
    case (op)
      0: if (m_assigned[v] || m_trail.size() == N) m_err = 1;
         else begin
           m_assigned[v] = 1; m_pol[v] = (lid / N) != 0; m_lvl[v] = lvl;
           m_rsn[v] = rsn; m_seen[v] = 0; m_trail.push_back(v);
         end
      1: if (!m_assigned[v]) m_err = 1; else set_exp(v);
      3: if (m_trail.size() == 0) m_err = 1;
         else begin
           t = m_trail.pop_back();
           set_exp(t);
           m_assigned[t] = 0;
         end
      default: ;
    endcase
    if (clr) for (int i = 0; i < N; i++) m_seen[i] = 0;
    if (op == 2) m_seen[v] = 1;
    AIT_enable = 1; AIT_opCode = 2'(op); AIT_LID = 5'(lid);
    Wr_Declevel = 4'(lvl); Wr_Reason = 4'(rsn); Clear_seen = clr;
    @(posedge Clk);
    #1;
    AIT_enable = 0; Clear_seen = 0;
  endtask

  task automatic backtrack(input int level, input int drop_lid, output int busy_cycles,
                           output int exp_pops);
    int t;
    wait_idle();
    exp_pops = 0;
    while (m_trail.size() > 0 && m_lvl[m_trail[$]] > level) begin
      t = m_trail.pop_back();
      m_assigned[t] = 0; m_seen[t] = 0;
      exp_pops++;
    end
    Bt_en = 1; Bt_level = 4'(level);
    AIT_enable = 1; AIT_opCode = 2'b00; AIT_LID = 5'(drop_lid); Wr_Declevel = 4'd1;
    @(posedge Clk);
    #1;
    Bt_en = 0; AIT_enable = 0;
    busy_cycles = 0;
    while (Busy === 1'b1 && busy_cycles < 64) begin
      busy_cycles++;
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    n_checks++;
    if ({AIT_valid, Busy, Trail_empty, Trail_full, Err} !== 5'b00100)
      $display("FAIL reset_status: valid/busy/empty/full/err=%b required 00100",
               {AIT_valid, Busy, Trail_empty, Trail_full, Err});
    else n_pass++;
    n_checks++;
    if ({AIT_LID_out, AIT_Seen, AIT_Declevel, AIT_Reason} !== 14'd0)
      $display("FAIL reset_fields: lid=%h seen=%b lvl=%h rsn=%h required all 0",
               AIT_LID_out, AIT_Seen, AIT_Declevel, AIT_Reason);
    else n_pass++;
  endtask

  task automatic test_assign_lookup();
    logic [4:0] held;
    apply_reset();
    step(0, 5'b1_0011, 2, 5, 0);
    n_checks++;
    if (AIT_valid !== 1'b0 || Trail_empty !== 1'b0)
      $display("FAIL assign_no_valid: valid=%b empty=%b required 0 0", AIT_valid, Trail_empty);
    else n_pass++;
    step(1, 5'b0_0011, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b1 || AIT_LID_out !== 5'b1_0011 || AIT_Declevel !== 4'd2 ||
        AIT_Reason !== 4'd5 || AIT_Seen !== 1'b0)
      $display("FAIL lookup_vid3: valid=%b lid=%b lvl=%0d rsn=%0d seen=%b required 1 10011 2 5 0",
               AIT_valid, AIT_LID_out, AIT_Declevel, AIT_Reason, AIT_Seen);
    else n_pass++;
    held = AIT_LID_out;
    @(posedge Clk);
    #1;
    n_checks++;
    if (AIT_valid !== 1'b0 || AIT_LID_out !== 5'b1_0011 || AIT_Declevel !== 4'd2)
      $display("FAIL response_hold: valid=%b lid=%b lvl=%0d required 0 10011 2",
               AIT_valid, AIT_LID_out, AIT_Declevel);
    else n_pass++;
    step(1, 7, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b0 || Err !== 1'b1 || AIT_LID_out !== held)
      $display("FAIL lookup_unassigned: valid=%b err=%b lid=%b required 0 1 %b",
               AIT_valid, Err, AIT_LID_out, held);
    else n_pass++;
    step(0, 3, 9, 9, 0);
    step(1, 3, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b1 || AIT_LID_out !== 5'b1_0011 || AIT_Declevel !== 4'd2)
      $display("FAIL double_assign_kept: valid=%b lid=%b lvl=%0d required 1 10011 2",
               AIT_valid, AIT_LID_out, AIT_Declevel);
    else n_pass++;
  endtask

  task automatic test_pop_order();
    int order[3];
    order = '{3, 2, 1};
    apply_reset();
    step(0, 16 + 1, 1, 1, 0);
    step(0, 2, 2, 2, 0);
    step(0, 16 + 3, 4, 3, 0);
    for (int i = 0; i < 3; i++) begin
      step(3, 0, 0, 0, 0);
      n_checks++;
      if (AIT_valid !== 1'b1 || AIT_LID_out[3:0] !== 4'(order[i]) || AIT_LID_out !== exp_lid ||
          AIT_Declevel !== exp_lvl)
        $display("FAIL pop_%0d: valid=%b lid=%b lvl=%0d required 1 %b %0d",
                 i, AIT_valid, AIT_LID_out, AIT_Declevel, exp_lid, exp_lvl);
      else n_pass++;
    end
    n_checks++;
    if (Err !== 1'b0)
      $display("FAIL pop_no_err: err=%b required 0", Err);
    else n_pass++;
    step(3, 0, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b0 || Err !== 1'b1 || Trail_empty !== 1'b1)
      $display("FAIL pop_underflow: valid=%b err=%b empty=%b required 0 1 1",
               AIT_valid, Err, Trail_empty);
    else n_pass++;
  endtask

  task automatic test_backtrack();
    int busy, pops;
    apply_reset();
    for (int i = 1; i <= 4; i++) step(0, i, i, i, 0);
    backtrack(2, 9, busy, pops);
    n_checks++;
    if (busy !== 2 || pops !== 2)
      $display("FAIL bt_busy_cycles: busy=%0d pops=%0d required 2 2", busy, pops);
    else n_pass++;
    for (int i = 3; i <= 4; i++) begin
      step(1, i, 0, 0, 0);
      n_checks++;
      if (AIT_valid !== 1'b0)
        $display("FAIL bt_unassigned_vid%0d: valid=%b required 0", i, AIT_valid);
      else n_pass++;
    end
    step(1, 9, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b0)
      $display("FAIL bt_dropped_request: valid=%b required 0", AIT_valid);
    else n_pass++;
    for (int i = 2; i >= 1; i--) begin
      step(3, 0, 0, 0, 0);
      n_checks++;
      if (AIT_valid !== 1'b1 || AIT_LID_out !== 5'(i) || AIT_Declevel !== 4'(i))
        $display("FAIL bt_remaining_%0d: valid=%b lid=%b lvl=%0d required 1 %b %0d",
                 i, AIT_valid, AIT_LID_out, AIT_Declevel, 5'(i), i);
      else n_pass++;
    end
    n_checks++;
    if (Trail_empty !== 1'b1)
      $display("FAIL bt_tp2: empty=%b required 1", Trail_empty);
    else n_pass++;
  endtask

  task automatic test_seen();
    apply_reset();
    step(0, 3, 1, 1, 0);
    step(0, 5, 1, 1, 0);
    step(2, 3, 0, 0, 0);
    step(1, 3, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b1 || AIT_Seen !== 1'b1)
      $display("FAIL seen_set_vid3: valid=%b seen=%b required 1 1", AIT_valid, AIT_Seen);
    else n_pass++;
    step(2, 5, 0, 0, 1);
    step(1, 3, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b1 || AIT_Seen !== 1'b0)
      $display("FAIL seen_cleared_vid3: valid=%b seen=%b required 1 0", AIT_valid, AIT_Seen);
    else n_pass++;
    step(1, 5, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b1 || AIT_Seen !== 1'b1)
      $display("FAIL seen_wins_vid5: valid=%b seen=%b required 1 1", AIT_valid, AIT_Seen);
    else n_pass++;
  endtask

  task automatic test_full();
    int bad;
    apply_reset();
    for (int i = 0; i < N; i++) step(0, i, i, 15 - i, 0);
    n_checks++;
    if (Trail_full !== 1'b1 || Err !== 1'b0)
      $display("FAIL full_after_16: full=%b err=%b required 1 0", Trail_full, Err);
    else n_pass++;
    step(0, 16 + 4, 0, 0, 0);
    n_checks++;
    if (Trail_full !== 1'b1 || Err !== 1'b1)
      $display("FAIL push_overflow: full=%b err=%b required 1 1", Trail_full, Err);
    else n_pass++;
    bad = 0;
    for (int i = N - 1; i >= 0; i--) begin
      step(3, 0, 0, 0, 0);
      if (AIT_valid !== 1'b1 || AIT_LID_out !== 5'(i) || AIT_Reason !== 4'(15 - i)) bad++;
    end
    n_checks++;
    if (bad !== 0 || Trail_empty !== 1'b1)
      $display("FAIL full_drain: bad_pops=%0d empty=%b required 0 1", bad, Trail_empty);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq;
    apply_reset();
    step(0, 6, 3, 4, 0);
    @(negedge Clk);
    AIT_enable = 1; AIT_opCode = 2'b01; AIT_LID = 5'd6;
    for (int k = 0; k < 4; k++) begin
      @(posedge Clk);
      #1;
      seq[3 - k] = AIT_valid;
    end
    AIT_enable = 0;
    n_checks++;
    if (seq !== 4'b1010)
      $display("FAIL back_to_back: valid pattern=%b required 1010", seq);
    else n_pass++;
  endtask

  task automatic test_random();
    int op, busy, pops;
    apply_reset();
    for (int s = 0; s < 300; s++) begin
      if (s % 37 == 36) begin
        backtrack($urandom_range(0, 15), $urandom_range(0, 31), busy, pops);
        n_checks++;
        if (busy !== ((pops > 0) ? pops : 1) || Err !== m_err)
          $display("FAIL rnd_bt_%0d: busy=%0d err=%b required %0d %b",
                   s, busy, Err, (pops > 0) ? pops : 1, m_err);
        else n_pass++;
        continue;
      end
      op = $urandom_range(0, 9);
      op = (op < 4) ? 0 : (op < 7) ? 1 : (op < 8) ? 2 : 3;
      step(op, $urandom_range(0, 31), $urandom_range(0, 15), $urandom_range(0, 15),
           $urandom_range(0, 7) == 0);
      n_checks++;
      if (AIT_valid !== exp_valid ||
          (exp_valid && {AIT_LID_out, AIT_Declevel, AIT_Reason, AIT_Seen} !==
                        {exp_lid, exp_lvl, exp_rsn, exp_seen}))
        $display("FAIL rnd_resp_%0d: op=%0d valid=%b lid=%b lvl=%0d rsn=%0d seen=%b required %b %b %0d %0d %b",
                 s, op, AIT_valid, AIT_LID_out, AIT_Declevel, AIT_Reason, AIT_Seen,
                 exp_valid, exp_lid, exp_lvl, exp_rsn, exp_seen);
      else n_pass++;
      n_checks++;
      if (Err !== m_err || Trail_empty !== (m_trail.size() == 0) ||
          Trail_full !== (m_trail.size() == N))
        $display("FAIL rnd_status_%0d: err=%b empty=%b full=%b required %b %b %b",
                 s, Err, Trail_empty, Trail_full, m_err, m_trail.size() == 0,
                 m_trail.size() == N);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_bt();
    apply_reset();
    for (int i = 0; i < 6; i++) step(0, i, i + 1, 0, 0);
    wait_idle();
    Bt_en = 1; Bt_level = 4'd0;
    @(posedge Clk);
    #1;
    Bt_en = 0;
    @(posedge Clk);
    #1;
    n_checks++;
    if (Busy !== 1'b1)
      $display("FAIL mid_bt_busy: busy=%b required 1", Busy);
    else n_pass++;
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    n_checks++;
    if (Busy !== 1'b0 || Trail_empty !== 1'b1 || AIT_valid !== 1'b0)
      $display("FAIL mid_bt_reset_async: busy=%b empty=%b valid=%b required 0 1 0",
               Busy, Trail_empty, AIT_valid);
    else n_pass++;
    @(posedge Clk);
    #1;
    n_checks++;
    if (Busy !== 1'b0 || Trail_empty !== 1'b1 || AIT_valid !== 1'b0 || Err !== 1'b0)
      $display("FAIL mid_bt_reset_edge: busy=%b empty=%b valid=%b err=%b required 0 1 0 0",
               Busy, Trail_empty, AIT_valid, Err);
    else n_pass++;
    @(negedge Clk);
    Reset = 1'b0;
    model_reset();
    step(1, 0, 0, 0, 0);
    n_checks++;
    if (AIT_valid !== 1'b0)
      $display("FAIL mid_bt_assigned_cleared: valid=%b required 0", AIT_valid);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_assign_lookup();
    test_pop_order();
    test_backtrack();
    test_seen();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid_bt();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
